// File: rtl/nv_nvdla_sdp_rdma_rd_arb_if.sv
// Bus bundle between the SDP read clients, the read arbiter and the RDMA dmaif.
// Pure wiring: no state and no latency.
// Valid/ready on every channel; the arbiter connects through the slave modport.
interface nv_nvdla_sdp_rdma_rd_arb_if #(
  parameter int REQ_PD_W = 79,
  parameter int RSP_PD_W = 514
);
  logic [2:0]            clt_rd_req_vld;
  logic [2:0]            clt_rd_req_rdy;
  logic [3*REQ_PD_W-1:0] clt_rd_req_pd;
  logic [2:0]            clt_rd_req_ram_type;
  logic [2:0]            clt_rd_rsp_vld;
  logic [2:0]            clt_rd_rsp_rdy;
  logic [RSP_PD_W-1:0]   clt_rd_rsp_pd;
  logic                  dma_rd_req_vld;
  logic                  dma_rd_req_rdy;
  logic [REQ_PD_W-1:0]   dma_rd_req_pd;
  logic                  dma_rd_req_ram_type;
  logic                  dma_rd_rsp_vld;
  logic                  dma_rd_rsp_rdy;
  logic [RSP_PD_W-1:0]   dma_rd_rsp_pd;
  logic                  dma_rd_rsp_ram_type;

  // Arbiter view
  modport slave (
    input  clt_rd_req_vld, clt_rd_req_pd, clt_rd_req_ram_type, clt_rd_rsp_rdy,
           dma_rd_req_rdy, dma_rd_rsp_vld, dma_rd_rsp_pd,
    output clt_rd_req_rdy, clt_rd_rsp_vld, clt_rd_rsp_pd,
           dma_rd_req_vld, dma_rd_req_pd, dma_rd_req_ram_type,
           dma_rd_rsp_rdy, dma_rd_rsp_ram_type
  );

  // Environment view (clients plus dmaif)
  modport master (
    output clt_rd_req_vld, clt_rd_req_pd, clt_rd_req_ram_type, clt_rd_rsp_rdy,
           dma_rd_req_rdy, dma_rd_rsp_vld, dma_rd_rsp_pd,
    input  clt_rd_req_rdy, clt_rd_rsp_vld, clt_rd_rsp_pd,
           dma_rd_req_vld, dma_rd_req_pd, dma_rd_req_ram_type,
           dma_rd_rsp_rdy, dma_rd_rsp_ram_type
  );
endinterface

// File: rtl/nv_nvdla_sdp_rdma_rd_arb.sv
// Round-robin share of one SDP RDMA read port among BRDMA/NRDMA/ERDMA, in-order response routing.
// Request: 1 cycle (registered slot); response: 0 cycles (combinational via tag FIFO head).
// Slot holds while dma rdy low; grants stop when slot busy or tag FIFO full. Optional NVDLA_SDP_RDMA_ARB_WEIGHT_EN.
module nv_nvdla_sdp_rdma_rd_arb #(
  parameter int REQ_PD_W  = 79,
  parameter int RSP_PD_W  = 514,
  parameter int SIZE_W    = 15,
  parameter int TAG_DEPTH = 8
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  nv_nvdla_sdp_rdma_rd_arb_if.slave   bus,
`ifdef NVDLA_SDP_RDMA_ARB_WEIGHT_EN
  input  logic [11:0]                 clt_wt,
`endif
  output logic                        arb_idle,
  output logic                        arb_rsp_err
);

  localparam int PTR_W  = $clog2(TAG_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = SIZE_W + 1;

  typedef struct packed {
    logic [1:0]        src;
    logic              ram_type;
    logic [BEAT_W-1:0] beats;
  } tag_t;

  // Tag FIFO state
  tag_t              tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  tag_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [1:0]        last_gnt;

  logic              tag_empty;
  logic              tag_full;
  tag_t              head;
  logic              slot_free;
  logic              can_grant;
  logic [5:0]        ord;
  logic [1:0]        win;
  logic              win_vld;
  logic              acc;
  logic [REQ_PD_W-1:0] sel_pd;
  logic              sel_ram_type;
  logic [SIZE_W-1:0] sel_size;
  tag_t              push_tag;
  logic              head_rdy;
  logic              rsp_hs;
  logic              last_beat;
  logic              pop;

`ifdef NVDLA_SDP_RDMA_ARB_WEIGHT_EN
  logic              burst_act;
  logic [4:0]        burst_cnt;
  logic              hold;
`endif

  assign tag_empty = (tag_cnt == '0);
  assign tag_full  = (tag_cnt == CNT_W'(TAG_DEPTH));
  assign head      = tag_mem[rd_ptr];
  assign slot_free = !bus.dma_rd_req_vld | bus.dma_rd_req_rdy;
  // A full tag FIFO blocks grants even if a pop happens this cycle.
  assign can_grant = slot_free & !tag_full;

  // Pick the winner: rotate from last_gnt+1, optionally let a weighted winner keep its grant
  always_comb begin
    case (last_gnt)
      2'd0:    ord = {2'd0, 2'd2, 2'd1};
      2'd1:    ord = {2'd1, 2'd0, 2'd2};
      default: ord = {2'd2, 2'd1, 2'd0};
    endcase
    win     = 2'd0;
    win_vld = 1'b0;
    // Scan lowest priority first so the highest-priority valid client is the last write.
    for (int k = 2; k >= 0; k--) begin
      if (bus.clt_rd_req_vld[ord[2*k +: 2]]) begin
        win     = ord[2*k +: 2];
        win_vld = 1'b1;
      end
    end
`ifdef NVDLA_SDP_RDMA_ARB_WEIGHT_EN
    hold = burst_act & bus.clt_rd_req_vld[last_gnt] &
           (burst_cnt <= {1'b0, clt_wt[{last_gnt, 2'b00} +: 4]});
    if (hold) begin
      win     = last_gnt;
      win_vld = 1'b1;
    end
`endif
  end

  assign acc                = can_grant & win_vld;
  assign bus.clt_rd_req_rdy = acc ? (3'b001 << win) : 3'b000;

  // Payload and ram type of the winning client
  always_comb begin
    case (win)
      2'd1:    begin sel_pd = bus.clt_rd_req_pd[REQ_PD_W   +: REQ_PD_W]; sel_ram_type = bus.clt_rd_req_ram_type[1]; end
      2'd2:    begin sel_pd = bus.clt_rd_req_pd[2*REQ_PD_W +: REQ_PD_W]; sel_ram_type = bus.clt_rd_req_ram_type[2]; end
      default: begin sel_pd = bus.clt_rd_req_pd[0          +: REQ_PD_W]; sel_ram_type = bus.clt_rd_req_ram_type[0]; end
    endcase
  end

  assign sel_size          = sel_pd[REQ_PD_W-1 -: SIZE_W];
  assign push_tag.src      = win;
  assign push_tag.ram_type = sel_ram_type;
  assign push_tag.beats    = BEAT_W'(sel_size) + BEAT_W'(1);

  // Output request slot and round-robin pointer
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      bus.dma_rd_req_vld      <= 1'b0;
      bus.dma_rd_req_pd       <= '0;
      bus.dma_rd_req_ram_type <= 1'b0;
      last_gnt                <= 2'd2;
    end else if (acc) begin
      bus.dma_rd_req_vld      <= 1'b1;
      bus.dma_rd_req_pd       <= sel_pd;
      bus.dma_rd_req_ram_type <= sel_ram_type;
      last_gnt                <= win;
    end else if (bus.dma_rd_req_rdy) begin
      bus.dma_rd_req_vld      <= 1'b0;
    end
  end

`ifdef NVDLA_SDP_RDMA_ARB_WEIGHT_EN
  // Burst bookkeeping: accepts granted to last_gnt in its current burst
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      burst_act <= 1'b0;
      burst_cnt <= 5'd0;
    end else if (acc) begin
      burst_act <= 1'b1;
      burst_cnt <= hold ? burst_cnt + 5'd1 : 5'd1;
    end else if (!bus.clt_rd_req_vld[last_gnt]) begin
      burst_act <= 1'b0;
    end
  end
`endif

  // Response routing from the tag FIFO head
  always_comb begin
    case (head.src)
      2'd0:    head_rdy = bus.clt_rd_rsp_rdy[0];
      2'd1:    head_rdy = bus.clt_rd_rsp_rdy[1];
      2'd2:    head_rdy = bus.clt_rd_rsp_rdy[2];
      default: head_rdy = 1'b0;
    endcase
  end

  assign bus.dma_rd_rsp_rdy      = !tag_empty & head_rdy;
  assign bus.clt_rd_rsp_vld      = (bus.dma_rd_rsp_vld & !tag_empty) ? (3'b001 << head.src) : 3'b000;
  assign bus.clt_rd_rsp_pd       = bus.dma_rd_rsp_pd[RSP_PD_W-1:0];
  assign bus.dma_rd_rsp_ram_type = !tag_empty & head.ram_type;

  assign rsp_hs    = bus.dma_rd_rsp_vld & bus.dma_rd_rsp_rdy;
  assign last_beat = (beat_cnt == head.beats - BEAT_W'(1));
  assign pop       = rsp_hs & last_beat;

  // Tag storage write; contents need no reset since tag_cnt qualifies them
  always_ff @(posedge nvdla_core_clk) begin
    if (acc) tag_mem[wr_ptr] <= push_tag;
  end

  // Tag FIFO pointers, occupancy and beat counter
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({acc, pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
      if (rsp_hs) beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
    end
  end

  // Sticky flag for a response with no outstanding request to own it
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)                     arb_rsp_err <= 1'b0;
    else if (bus.dma_rd_rsp_vld & tag_empty)  arb_rsp_err <= 1'b1;
  end

  assign arb_idle = !bus.dma_rd_req_vld & tag_empty;

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_rd_arb.sv
// Bench for the SDP RDMA read arbiter: grant order, response routing, tag limit, backpressure, error flag.
// Inputs driven 1 ns after posedge, outputs sampled on negedge.
// Expected request payloads and response owners queued at accept time and popped on DUT handshakes.
module tb_nv_nvdla_sdp_rdma_rd_arb;

  localparam int REQ_PD_W = 79;
  localparam int RSP_PD_W = 514;

  logic nvdla_core_clk;
  logic nvdla_core_rstn;
  logic arb_idle;
  logic arb_rsp_err;
`ifdef NVDLA_SDP_RDMA_ARB_WEIGHT_EN
  logic [11:0] clt_wt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [REQ_PD_W-1:0] req_q[$];
  int                  rsp_q[$];   // src*2 + ram_type per beat

  nv_nvdla_sdp_rdma_rd_arb_if #(.REQ_PD_W(REQ_PD_W), .RSP_PD_W(RSP_PD_W)) bus ();

  nv_nvdla_sdp_rdma_rd_arb #(
    .REQ_PD_W(REQ_PD_W), .RSP_PD_W(RSP_PD_W), .SIZE_W(15), .TAG_DEPTH(8)
  ) dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .bus             (bus),
`ifdef NVDLA_SDP_RDMA_ARB_WEIGHT_EN
    .clt_wt          (clt_wt),
`endif
    .arb_idle        (arb_idle),
    .arb_rsp_err     (arb_rsp_err)
  );

  initial nvdla_core_clk = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  function automatic logic [REQ_PD_W-1:0] mk_pd(int size, int tag);
    return {15'(size), 64'h0000_0001_0000_0000 + 64'(tag)};
  endfunction

  task automatic tick();
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clt_rd_req_vld      = 3'b000;
    bus.clt_rd_req_pd       = '0;
    bus.clt_rd_req_ram_type = 3'b000;
    bus.clt_rd_rsp_rdy      = 3'b111;
    bus.dma_rd_req_rdy      = 1'b1;
    bus.dma_rd_rsp_vld      = 1'b0;
    bus.dma_rd_rsp_pd       = '0;
`ifdef NVDLA_SDP_RDMA_ARB_WEIGHT_EN
    clt_wt = 12'h000;
`endif
  endtask

  task automatic do_reset();
    nvdla_core_rstn = 1'b0;
    idle_inputs();
    req_q.delete();
    rsp_q.delete();
    repeat (2) @(posedge nvdla_core_clk);
    #1 nvdla_core_rstn = 1'b1;
  endtask

  task automatic set_clients(int size);
    for (int c = 0; c < 3; c++) begin
      bus.clt_rd_req_pd[c*REQ_PD_W +: REQ_PD_W] = mk_pd(size, c);
      bus.clt_rd_req_ram_type[c] = c[0];
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge nvdla_core_clk);
    n_tests++; if (bus.dma_rd_req_vld !== 1'b0) begin n_fail++; $display("FAIL reset_req_vld: got %0b want 0", bus.dma_rd_req_vld); end
    n_tests++; if (bus.dma_rd_req_pd !== '0) begin n_fail++; $display("FAIL reset_req_pd: got %0h want 0", bus.dma_rd_req_pd); end
    n_tests++; if (bus.dma_rd_req_ram_type !== 1'b0) begin n_fail++; $display("FAIL reset_req_ram_type: got %0b want 0", bus.dma_rd_req_ram_type); end
    n_tests++; if (arb_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0b want 1", arb_idle); end
    n_tests++; if (arb_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", arb_rsp_err); end
    n_tests++; if (bus.dma_rd_rsp_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_rdy: got %0b want 0", bus.dma_rd_rsp_rdy); end
    n_tests++; if (bus.dma_rd_rsp_ram_type !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_ram_type: got %0b want 0", bus.dma_rd_rsp_ram_type); end
  endtask

  // All clients valid: grants rotate 0,1,2,0,1,2 and each shows on the dma side one cycle later
  task automatic test_round_robin();
    logic [2:0] exp_rdy;
    logic [REQ_PD_W-1:0] exp_pd;
    do_reset();
    set_clients(0);
    bus.clt_rd_req_vld = 3'b111;
    for (int n = 0; n < 7; n++) begin
      @(negedge nvdla_core_clk);
      n_tests++;
      if (bus.dma_rd_req_vld !== (req_q.size() > 0)) begin
        n_fail++; $display("FAIL rr_req_vld cycle %0d: got %0b want %0b", n, bus.dma_rd_req_vld, req_q.size() > 0);
      end
      if (bus.dma_rd_req_vld === 1'b1 && req_q.size() > 0) begin
        exp_pd = req_q.pop_front();
        n_tests++;
        if (bus.dma_rd_req_pd !== exp_pd) begin n_fail++; $display("FAIL rr_req_pd cycle %0d: got %0h want %0h", n, bus.dma_rd_req_pd, exp_pd); end
      end
      exp_rdy = (n < 6) ? (3'b001 << (n % 3)) : 3'b000;
      n_tests++;
      if (bus.clt_rd_req_rdy !== exp_rdy) begin n_fail++; $display("FAIL rr_grant cycle %0d: got %b want %b", n, bus.clt_rd_req_rdy, exp_rdy); end
      if (n < 6) req_q.push_back(mk_pd(0, n % 3));
      tick();
      if (n == 5) bus.clt_rd_req_vld = 3'b000;
    end
  endtask

  // Client1 4-beat request then client0 1-beat request: beats routed in order
  task automatic test_rsp_route();
    int e;
    logic [2:0] exp_vld;
    do_reset();
    bus.clt_rd_req_pd[REQ_PD_W +: REQ_PD_W] = mk_pd(3, 1);
    bus.clt_rd_req_ram_type = 3'b010;
    bus.clt_rd_req_vld = 3'b010;
    @(negedge nvdla_core_clk);
    n_tests++; if (bus.clt_rd_req_rdy !== 3'b010) begin n_fail++; $display("FAIL route_grant1: got %b want 010", bus.clt_rd_req_rdy); end
    for (int b = 0; b < 4; b++) rsp_q.push_back(1*2 + 1);
    tick();
    bus.clt_rd_req_pd[0 +: REQ_PD_W] = mk_pd(0, 0);
    bus.clt_rd_req_vld = 3'b001;
    @(negedge nvdla_core_clk);
    n_tests++; if (bus.clt_rd_req_rdy !== 3'b001) begin n_fail++; $display("FAIL route_grant0: got %b want 001", bus.clt_rd_req_rdy); end
    rsp_q.push_back(0*2 + 0);
    tick();
    bus.clt_rd_req_vld = 3'b000;
    tick();
    // owner not ready: dmaif must be stalled while the owner still sees valid
    bus.dma_rd_rsp_vld = 1'b1;
    bus.clt_rd_rsp_rdy = 3'b101;
    @(negedge nvdla_core_clk);
    n_tests++; if (bus.dma_rd_rsp_rdy !== 1'b0) begin n_fail++; $display("FAIL route_stall_rdy: got %0b want 0", bus.dma_rd_rsp_rdy); end
    n_tests++; if (bus.clt_rd_rsp_vld !== 3'b010) begin n_fail++; $display("FAIL route_stall_vld: got %b want 010", bus.clt_rd_rsp_vld); end
    tick();
    bus.clt_rd_rsp_rdy = 3'b111;
    for (int b = 0; b < 5; b++) begin
      bus.dma_rd_rsp_pd = RSP_PD_W'(100 + b);
      @(negedge nvdla_core_clk);
      n_tests++;
      if (rsp_q.size() == 0 || bus.dma_rd_rsp_rdy !== 1'b1) begin
        n_fail++; $display("FAIL route_beat%0d_rdy: got %0b want 1", b, bus.dma_rd_rsp_rdy);
      end else begin
        e = rsp_q.pop_front();
        exp_vld = 3'b001 << (e / 2);
        n_tests++; if (bus.clt_rd_rsp_vld !== exp_vld) begin n_fail++; $display("FAIL route_beat%0d_vld: got %b want %b", b, bus.clt_rd_rsp_vld, exp_vld); end
        n_tests++; if (bus.dma_rd_rsp_ram_type !== e[0]) begin n_fail++; $display("FAIL route_beat%0d_ram_type: got %0b want %0b", b, bus.dma_rd_rsp_ram_type, e[0]); end
        if (bus.clt_rd_rsp_pd !== RSP_PD_W'(100 + b)) begin n_fail++; $display("FAIL route_beat%0d_pd: got %0h want %0h", b, bus.clt_rd_rsp_pd, 100 + b); end
      end
      tick();
    end
    bus.dma_rd_rsp_vld = 1'b0;
    @(negedge nvdla_core_clk);
    n_tests++; if (arb_idle !== 1'b1) begin n_fail++; $display("FAIL route_idle_after: got %0b want 1", arb_idle); end
    n_tests++; if (bus.dma_rd_rsp_rdy !== 1'b0) begin n_fail++; $display("FAIL route_rdy_after: got %0b want 0", bus.dma_rd_rsp_rdy); end
  endtask

  // Eight outstanding tags block further grants; one pop frees exactly one slot next cycle
  task automatic test_tag_full();
    logic [2:0] exp_rdy;
    do_reset();
    set_clients(0);
    bus.clt_rd_req_vld = 3'b001;
    for (int n = 0; n < 10; n++) begin
      @(negedge nvdla_core_clk);
      exp_rdy = (n < 8) ? 3'b001 : 3'b000;
      n_tests++; if (bus.clt_rd_req_rdy !== exp_rdy) begin n_fail++; $display("FAIL full_grant%0d: got %b want %b", n, bus.clt_rd_req_rdy, exp_rdy); end
      tick();
    end
    bus.dma_rd_rsp_vld = 1'b1;
    @(negedge nvdla_core_clk);
    n_tests++; if (bus.clt_rd_req_rdy !== 3'b000) begin n_fail++; $display("FAIL full_no_bypass: got %b want 000", bus.clt_rd_req_rdy); end
    n_tests++; if (bus.dma_rd_rsp_rdy !== 1'b1) begin n_fail++; $display("FAIL full_rsp_rdy: got %0b want 1", bus.dma_rd_rsp_rdy); end
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    @(negedge nvdla_core_clk);
    n_tests++; if (bus.clt_rd_req_rdy !== 3'b001) begin n_fail++; $display("FAIL full_freed: got %b want 001", bus.clt_rd_req_rdy); end
    tick();
    @(negedge nvdla_core_clk);
    n_tests++; if (bus.clt_rd_req_rdy !== 3'b000) begin n_fail++; $display("FAIL full_again: got %b want 000", bus.clt_rd_req_rdy); end
    tick();
    bus.clt_rd_req_vld = 3'b000;
  endtask

  // Slot held for 5 cycles under dma backpressure, then RR resumes at client1
  task automatic test_backpressure();
    logic [REQ_PD_W-1:0] exp_pd;
    do_reset();
    set_clients(0);
    bus.dma_rd_req_rdy = 1'b0;
    bus.clt_rd_req_vld = 3'b111;
    @(negedge nvdla_core_clk);
    n_tests++; if (bus.clt_rd_req_rdy !== 3'b001) begin n_fail++; $display("FAIL bp_first: got %b want 001", bus.clt_rd_req_rdy); end
    req_q.push_back(mk_pd(0, 0));
    tick();
    for (int n = 0; n < 5; n++) begin
      @(negedge nvdla_core_clk);
      n_tests++; if (bus.clt_rd_req_rdy !== 3'b000) begin n_fail++; $display("FAIL bp_hold_grant%0d: got %b want 000", n, bus.clt_rd_req_rdy); end
      n_tests++; if (bus.dma_rd_req_vld !== 1'b1 || bus.dma_rd_req_pd !== req_q[0]) begin
        n_fail++; $display("FAIL bp_hold_pd%0d: got vld %0b pd %0h want vld 1 pd %0h", n, bus.dma_rd_req_vld, bus.dma_rd_req_pd, req_q[0]);
      end
      tick();
    end
    bus.dma_rd_req_rdy = 1'b1;
    for (int n = 1; n < 3; n++) begin
      @(negedge nvdla_core_clk);
      exp_pd = req_q.pop_front();
      n_tests++; if (bus.dma_rd_req_vld !== 1'b1 || bus.dma_rd_req_pd !== exp_pd) begin
        n_fail++; $display("FAIL bp_release_pd%0d: got vld %0b pd %0h want pd %0h", n, bus.dma_rd_req_vld, bus.dma_rd_req_pd, exp_pd);
      end
      n_tests++; if (bus.clt_rd_req_rdy !== (3'b001 << n)) begin n_fail++; $display("FAIL bp_release_grant%0d: got %b want %b", n, bus.clt_rd_req_rdy, 3'b001 << n); end
      req_q.push_back(mk_pd(0, n));
      tick();
    end
    bus.clt_rd_req_vld = 3'b000;
  endtask

  // Response with no outstanding tag: stalled, sticky error until reset
  task automatic test_rsp_err();
    do_reset();
    bus.dma_rd_rsp_vld = 1'b1;
    @(negedge nvdla_core_clk);
    n_tests++; if (bus.dma_rd_rsp_rdy !== 1'b0) begin n_fail++; $display("FAIL err_rdy: got %0b want 0", bus.dma_rd_rsp_rdy); end
    n_tests++; if (bus.clt_rd_rsp_vld !== 3'b000) begin n_fail++; $display("FAIL err_clt_vld: got %b want 000", bus.clt_rd_rsp_vld); end
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    @(negedge nvdla_core_clk);
    n_tests++; if (arb_rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %0b want 1", arb_rsp_err); end
    repeat (3) tick();
    @(negedge nvdla_core_clk);
    n_tests++; if (arb_rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0b want 1", arb_rsp_err); end
    do_reset();
    @(negedge nvdla_core_clk);
    n_tests++; if (arb_rsp_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %0b want 0", arb_rsp_err); end
  endtask

`ifdef NVDLA_SDP_RDMA_ARB_WEIGHT_EN
  // Client0 weight 3 keeps the grant for 4 accepts before rotating
  task automatic test_weight();
    int seq [10] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 0};
    logic [2:0] exp_rdy;
    do_reset();
    set_clients(0);
    clt_wt = {4'd0, 4'd0, 4'd3};
    bus.dma_rd_rsp_vld = 1'b1;
    bus.clt_rd_req_vld = 3'b111;
    for (int n = 0; n < 10; n++) begin
      @(negedge nvdla_core_clk);
      exp_rdy = 3'b001 << seq[n];
      n_tests++; if (bus.clt_rd_req_rdy !== exp_rdy) begin n_fail++; $display("FAIL weight_grant%0d: got %b want %b", n, bus.clt_rd_req_rdy, exp_rdy); end
      tick();
    end
    bus.clt_rd_req_vld = 3'b000;
    bus.dma_rd_rsp_vld = 1'b0;
  endtask
`endif

  initial begin
    nvdla_core_rstn = 1'b0;
    test_reset();
    test_round_robin();
    test_rsp_route();
    test_tag_full();
    test_backpressure();
    test_rsp_err();
`ifdef NVDLA_SDP_RDMA_ARB_WEIGHT_EN
    test_weight();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
